clk_divider_multi: RTL and testbench

- Parametrised, multi-channel successor to the single-output clock divider.
- Each channel divides `clk` by a runtime-programmable ratio and produces two outputs: a one-cycle tick (clock enable) and a near-50% duty square wave.
- New divisors are written through a simple write port and take effect glitch-free at the channel's next period boundary.
- Feeds slow-rate logic: display refresh, debouncers, blinkers.

---
 rtl/clk_divider_multi.sv | 101 ++++++++++
 tb/tb_clk_divider_multi.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/clk_divider_multi.sv
// Multi-channel programmable clock divider: each channel emits a one-cycle tick and a near-50% square wave.
// Optional macro PHASE_ALIGN_EN adds a `sync` input that restarts every enabled channel at count 0.
module clk_divider_multi #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 27,
  parameter int CH_W        = 3,
  parameter int DEFAULT_DIV = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [CNT_W-1:0]  div_val,
  output logic [NUM_CH-1:0] pend,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] clk_out
`ifdef PHASE_ALIGN_EN
  ,
  input  logic              sync
`endif
);

  // Divisors below 2 cannot produce a tick period, so they are stored as 2.
  localparam logic [CNT_W-1:0] DEF_D = (DEFAULT_DIV < 2) ? CNT_W'(2) : CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] wr_val;
  logic             sync_int;

  assign wr_val = (div_val < CNT_W'(2)) ? CNT_W'(2) : div_val;

`ifdef PHASE_ALIGN_EN
  assign sync_int = sync;
`else
  assign sync_int = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic [CNT_W-1:0] div_reg, div_next;
      logic [CNT_W-1:0] pdiv_reg, pdiv_next;
      logic             pend_reg, pend_next;
      logic             tick_reg, tick_next;
      logic             clk_out_reg, clk_out_next;
      logic             wrap, wr_hit, apply;

      // Channel indices that do not exist never match, so such writes drop out here.
      assign wr_hit = div_wr && (div_ch == CH_W'(gi));

      always_comb begin
        wrap      = en[gi] && (cnt_reg == div_reg - CNT_W'(1));
        apply     = pend_reg && (!en[gi] || wrap || sync_int);
        tick_next = wrap && !sync_int;

        cnt_next = cnt_reg + CNT_W'(1);
        if (!en[gi] || sync_int || wrap) begin
          cnt_next = '0;
        end

        div_next  = apply ? pdiv_reg : div_reg;
        pdiv_next = wr_hit ? wr_val : pdiv_reg;

        // A write landing on the apply edge stays pending for the next boundary.
        pend_next = pend_reg;
        if (apply) begin
          pend_next = 1'b0;
        end
        if (wr_hit) begin
          pend_next = 1'b1;
        end

        // Computed from next-state values so clk_out lines up with the registered count.
        clk_out_next = en[gi] && (cnt_next >= (div_next >> 1));
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg     <= '0;
          div_reg     <= DEF_D;
          pdiv_reg    <= DEF_D;
          pend_reg    <= 1'b0;
          tick_reg    <= 1'b0;
          clk_out_reg <= 1'b0;
        end else begin
          cnt_reg     <= cnt_next;
          div_reg     <= div_next;
          pdiv_reg    <= pdiv_next;
          pend_reg    <= pend_next;
          tick_reg    <= tick_next;
          clk_out_reg <= clk_out_next;
        end
      end

      assign pend[gi]    = pend_reg;
      assign tick[gi]    = tick_reg;
      assign clk_out[gi] = clk_out_reg;
    end
  endgenerate

endmodule

// File: tb/tb_clk_divider_multi.sv
// Randomised and directed checks of clk_divider_multi against a cycle-level arithmetic reference model.
module tb_clk_divider_multi;
  localparam int NUM_CH      = 2;
  localparam int CNT_W       = 8;
  localparam int CH_W        = 3;
  localparam int DEFAULT_DIV = 7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_CH-1:0] en = '0;
  logic              div_wr = 1'b0;
  logic [CH_W-1:0]   div_ch = '0;
  logic [CNT_W-1:0]  div_val = '0;
  logic              sync = 1'b0;
  logic [NUM_CH-1:0] pend, tick, clk_out;

  always #5 clk = ~clk;

  clk_divider_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div_wr(div_wr), .div_ch(div_ch),
    .div_val(div_val), .pend(pend), .tick(tick), .clk_out(clk_out)
`ifdef PHASE_ALIGN_EN
    , .sync(sync)
`endif
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: count position, active divisor, pending divisor per channel.
  int m_cnt[NUM_CH], m_d[NUM_CH], m_pd[NUM_CH];
  bit m_pend[NUM_CH], m_tick[NUM_CH], m_clk[NUM_CH];
  int tick_cnt[NUM_CH], hi_cnt[NUM_CH];

  function automatic int clampv(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_cnt[c] = 0; m_d[c] = clampv(DEFAULT_DIV); m_pd[c] = clampv(DEFAULT_DIV);
      m_pend[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
    end
  endtask

  task automatic model_step(input logic [NUM_CH-1:0] e, input bit w, input int ch, input int v, input bit sy);
    for (int c = 0; c < NUM_CH; c++) begin
      bit run, last, take;
      run  = e[c];
      last = run && (m_cnt[c] == m_d[c] - 1);
      m_tick[c] = last && !sy;
      take = m_pend[c] && (!run || last || sy);
      m_cnt[c] = (!run || sy) ? 0 : (m_cnt[c] + 1) % m_d[c];
      if (take) begin
        m_d[c] = m_pd[c];
        m_pend[c] = 0;
      end
      if (w && ch == c) begin
        m_pd[c] = clampv(v);
        m_pend[c] = 1;
      end
      m_clk[c] = run && (m_cnt[c] >= m_d[c] / 2);
    end
  endtask

  function automatic logic [NUM_CH-1:0] pack(input bit a[NUM_CH]);
    logic [NUM_CH-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c] = a[c];
    return r;
  endfunction

  // One clock: drive after the falling edge, advance the model at the rising edge, compare at the next falling edge.
  task automatic step(input logic [NUM_CH-1:0] e, input bit w, input int ch, input int v, input bit s);
    en = e; div_wr = w; div_ch = ch[CH_W-1:0]; div_val = v[CNT_W-1:0]; sync = s;
    @(posedge clk);
    model_step(e, w, ch, v, s);
    @(negedge clk);
    check_val("tick", 32'(tick), 32'(pack(m_tick)));
    check_val("clk_out", 32'(clk_out), 32'(pack(m_clk)));
    check_val("pend", 32'(pend), 32'(pack(m_pend)));
    for (int c = 0; c < NUM_CH; c++) begin
      tick_cnt[c] += int'(tick[c]);
      hi_cnt[c]   += int'(clk_out[c]);
    end
  endtask

  task automatic clear_counts();
    for (int c = 0; c < NUM_CH; c++) begin
      tick_cnt[c] = 0; hi_cnt[c] = 0;
    end
  endtask

  task automatic run(input logic [NUM_CH-1:0] e, input int n);
    for (int i = 0; i < n; i++) step(e, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_val("rst_tick", 32'(tick), 0);
    check_val("rst_clk_out", 32'(clk_out), 0);
    check_val("rst_pend", 32'(pend), 0);
    rst_n = 1'b1;

    // ch0 divisor 4 programmed while idle, then only ch0 runs
    step(2'b00, 1, 0, 4, 0);
    check_val("wr_idle_pend", 32'(pend[0]), 1);
    step(2'b00, 0, 0, 0, 0);
    check_val("idle_apply_pend", 32'(pend[0]), 0);
    clear_counts();
    run(2'b01, 16);
    check_val("d4_ticks", tick_cnt[0], 4);
    check_val("d4_high", hi_cnt[0], 8);
    check_val("ch1_off_ticks", tick_cnt[1], 0);
    check_val("ch1_off_high", hi_cnt[1], 0);

    // odd divisor on ch1
    step(2'b01, 1, 1, 5, 0);
    step(2'b01, 0, 0, 0, 0);
    clear_counts();
    run(2'b11, 20);
    check_val("d5_ticks", tick_cnt[1], 4);
    check_val("d5_high", hi_cnt[1], 12);
    check_val("d4_keep_ticks", tick_cnt[0], 5);
    check_val("d4_keep_high", hi_cnt[0], 10);

    // mid-period divisor change on ch0 when its count is 1
    for (int i = 0; i < 8 && m_cnt[0] != 1; i++) step(2'b11, 0, 0, 0, 0);
    check_val("mid_cnt_found", m_cnt[0], 1);
    step(2'b11, 1, 0, 10, 0);
    check_val("mid_pend", 32'(pend[0]), 1);
    run(2'b11, 40);

    // clamp of 0 to 2, and a write to a channel that does not exist
    step(2'b00, 1, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0);
    step(2'b00, 1, 7, 9, 0);
    check_val("ign_pend", 32'(pend), 0);
    clear_counts();
    run(2'b01, 10);
    check_val("clamp_ticks", tick_cnt[0], 5);

    // asynchronous reset between edges drops everything at once
    step(2'b11, 1, 1, 3, 0);
    run(2'b11, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_tick", 32'(tick), 0);
    check_val("arst_clk_out", 32'(clk_out), 0);
    check_val("arst_pend", 32'(pend), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    run(2'b11, 21);
    check_val("post_rst_ch0_ticks", tick_cnt[0], 3);
    check_val("post_rst_ch1_ticks", tick_cnt[1], 3);

`ifdef PHASE_ALIGN_EN
    begin
      int first0, first1;
      step(2'b00, 1, 0, 4, 0);
      step(2'b00, 1, 1, 6, 0);
      step(2'b00, 0, 0, 0, 0);
      run(2'b01, 3);
      run(2'b11, 5);
      step(2'b11, 0, 0, 0, 1);
      first0 = -1; first1 = -1;
      for (int i = 1; i <= 20 && (first0 < 0 || first1 < 0); i++) begin
        step(2'b11, 0, 0, 0, 0);
        if (tick[0] && first0 < 0) first0 = i;
        if (tick[1] && first1 < 0) first1 = i;
      end
      check_val("sync_first_ch0", first0, 4);
      check_val("sync_first_ch1", first1, 6);
    end
`endif

    // random traffic
    begin
      logic [NUM_CH-1:0] e;
      e = 2'b11;
      for (int i = 0; i < 800; i++) begin
        bit w, s;
        int ch, v;
        for (int c = 0; c < NUM_CH; c++) begin
          if ($urandom_range(0, 15) == 0) e[c] = ~e[c];
        end
        w  = ($urandom_range(0, 3) == 0);
        ch = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 2);
        v  = $urandom_range(0, 12);
`ifdef PHASE_ALIGN_EN
        s = ($urandom_range(0, 19) == 0);
`else
        s = 0;
`endif
        step(e, w, ch, v, s);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
